// File: rtl/maze_pkg.sv
// Shared definitions for the maze bot run sequencer.
// Contents: move command codes, heading encoding, sequencer state enum,
// default grid / start / exit / move-budget constants and a move-legality helper.
package maze_pkg;

    // Move command codes shared by the explorer and the motion executor.
    typedef enum logic [2:0] {
        MV_STOP  = 3'd0,
        MV_FWD   = 3'd1,
        MV_LEFT  = 3'd2,
        MV_RIGHT = 3'd3,
        MV_UTURN = 3'd4
    } move_e;

    // Compass heading; N is +y and E is +x, so "+1 mod 4" is a right turn.
    typedef enum logic [1:0] {
        HD_N = 2'd0,
        HD_E = 2'd1,
        HD_S = 2'd2,
        HD_W = 2'd3
    } heading_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SENSE,
        ST_STEP,
        ST_FETCH,
        ST_ISSUE,
        ST_UPDATE,
        ST_HALT,
        ST_DONE,
        ST_FAULT
    } state_e;

    localparam int DEF_ROWS      = 9;
    localparam int DEF_COLS      = 9;
    localparam int DEF_START_X   = 4;
    localparam int DEF_START_Y   = 0;
    localparam int DEF_EXIT_X    = 4;
    localparam int DEF_EXIT_Y    = 8;
    localparam int DEF_MAX_MOVES = 200;

    // Only FWD, LEFT, RIGHT and U_TURN are movement commands from the explorer.
    function automatic logic is_legal_move(input logic [2:0] m);
        return (m >= 3'd1) && (m <= 3'd4);
    endfunction

endpackage

// File: rtl/maze_pose_tracker.sv
// Combinational next-pose calculator for the maze bot.
// Inputs : heading_i (current heading), pos_x_i / pos_y_i (current cell),
//          move_i (move code being executed).
// Outputs: next_heading_o, next_x_o / next_y_o (cell after turn + one step),
//          oob_o (next cell is outside the grid), is_uturn_o (move is U_TURN).
module maze_pose_tracker
    import maze_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
) (
    input  logic [1:0] heading_i,
    input  logic [3:0] pos_x_i,
    input  logic [3:0] pos_y_i,
    input  logic [2:0] move_i,
    output logic [1:0] next_heading_o,
    output logic [3:0] next_x_o,
    output logic [3:0] next_y_o,
    output logic       oob_o,
    output logic       is_uturn_o
);

    localparam logic signed [4:0] MAX_X = 5'(COLS - 1);
    localparam logic signed [4:0] MAX_Y = 5'(ROWS - 1);

    logic signed [4:0] dx;
    logic signed [4:0] dy;
    logic signed [4:0] nx;
    logic signed [4:0] ny;

    // The turn is applied first; the single-cell step then follows the new
    // heading. Signed 5-bit sums let a step off row/column 0 show up as -1.
    always_comb begin
        next_heading_o = heading_i;
        is_uturn_o     = 1'b0;
        case (move_i)
            MV_LEFT:  next_heading_o = heading_i - 2'd1;
            MV_RIGHT: next_heading_o = heading_i + 2'd1;
            MV_UTURN: begin
                next_heading_o = heading_i + 2'd2;
                is_uturn_o     = 1'b1;
            end
            default: ;
        endcase

        dx = 5'sd0;
        dy = 5'sd0;
        case (next_heading_o)
            HD_N:    dy = 5'sd1;
            HD_E:    dx = 5'sd1;
            HD_S:    dy = -5'sd1;
            default: dx = -5'sd1;
        endcase

        nx = $signed({1'b0, pos_x_i}) + dx;
        ny = $signed({1'b0, pos_y_i}) + dy;

        oob_o    = (nx < 5'sd0) || (nx > MAX_X) || (ny < 5'sd0) || (ny > MAX_Y);
        next_x_o = nx[3:0];
        next_y_o = ny[3:0];
    end

endmodule

// File: rtl/maze_run_sequencer.sv
// Sequences one exploration run of the maze bot.
// Ports: clk/rst (async active-high); start; sense_valid + left/mid/right wall
// bits from the sensor front-end; exp_left/mid/right, exp_step, exp_hold to the
// explorer and exp_move back from it; cmd_valid/cmd/cmd_ready to the motion
// executor; pos_x/pos_y, heading, dead_ends, move_cnt, busy/done/fault status.
module maze_run_sequencer
    import maze_pkg::*;
#(
    parameter int ROWS      = DEF_ROWS,
    parameter int COLS      = DEF_COLS,
    parameter int START_X   = DEF_START_X,
    parameter int START_Y   = DEF_START_Y,
    parameter int EXIT_X    = DEF_EXIT_X,
    parameter int EXIT_Y    = DEF_EXIT_Y,
    parameter int MAX_MOVES = DEF_MAX_MOVES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       sense_valid,
    input  logic       left,
    input  logic       mid,
    input  logic       right,
    output logic       exp_left,
    output logic       exp_mid,
    output logic       exp_right,
    output logic       exp_step,
    output logic       exp_hold,
    input  logic [2:0] exp_move,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    input  logic       cmd_ready,
    output logic [3:0] pos_x,
    output logic [3:0] pos_y,
    output logic [1:0] heading,
    output logic [3:0] dead_ends,
    output logic [7:0] move_cnt,
    output logic       busy,
    output logic       done,
    output logic       fault
);

    localparam logic [3:0] START_X_V = 4'(START_X);
    localparam logic [3:0] START_Y_V = 4'(START_Y);
    localparam logic [3:0] EXIT_X_V  = 4'(EXIT_X);
    localparam logic [3:0] EXIT_Y_V  = 4'(EXIT_Y);
    localparam logic [7:0] MAX_V     = 8'(MAX_MOVES);

    state_e     state_q, state_d;
    logic [3:0] pos_x_q, pos_x_d;
    logic [3:0] pos_y_q, pos_y_d;
    logic [1:0] heading_q, heading_d;
    logic [3:0] dead_q, dead_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] walls_q, walls_d;
    logic [2:0] code_q, code_d;

    logic [1:0] nh;
    logic [3:0] nx;
    logic [3:0] ny;
    logic       oob;
    logic       uturn;

    maze_pose_tracker #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_pose (
        .heading_i      (heading_q),
        .pos_x_i        (pos_x_q),
        .pos_y_i        (pos_y_q),
        .move_i         (code_q),
        .next_heading_o (nh),
        .next_x_o       (nx),
        .next_y_o       (ny),
        .oob_o          (oob),
        .is_uturn_o     (uturn)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pos_x_q   <= START_X_V;
            pos_y_q   <= START_Y_V;
            heading_q <= HD_N;
            dead_q    <= 4'd0;
            cnt_q     <= 8'd0;
            walls_q   <= 3'd0;
            code_q    <= 3'd0;
        end else begin
            state_q   <= state_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            heading_q <= heading_d;
            dead_q    <= dead_d;
            cnt_q     <= cnt_d;
            walls_q   <= walls_d;
            code_q    <= code_d;
        end
    end

    // Next-state and Moore outputs. Outputs depend only on state_q so that an
    // asynchronous reset drops cmd_valid immediately.
    always_comb begin
        state_d   = state_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        heading_d = heading_q;
        dead_d    = dead_q;
        cnt_d     = cnt_q;
        walls_d   = walls_q;
        code_d    = code_q;

        exp_step  = 1'b0;
        exp_hold  = 1'b0;
        cmd_valid = 1'b0;
        cmd       = MV_STOP;
        busy      = 1'b0;
        done      = 1'b0;
        fault     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_FAULT: begin
                exp_hold = 1'b1;
                done     = (state_q == ST_DONE);
                fault    = (state_q == ST_FAULT);
                if (start) begin
                    state_d   = ST_SENSE;
                    pos_x_d   = START_X_V;
                    pos_y_d   = START_Y_V;
                    heading_d = HD_N;
                    dead_d    = 4'd0;
                    cnt_d     = 8'd0;
                end
            end
            ST_SENSE: begin
                busy = 1'b1;
                if (sense_valid) begin
                    walls_d = {left, mid, right};
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                busy     = 1'b1;
                exp_step = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_FETCH: begin
                busy    = 1'b1;
                code_d  = exp_move;
                state_d = is_legal_move(exp_move) ? ST_ISSUE : ST_FAULT;
            end
            ST_ISSUE: begin
                busy      = 1'b1;
                cmd_valid = 1'b1;
                cmd       = code_q;
                if (cmd_ready) state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                // Heading and counters commit even when the step leaves the
                // grid; the position only commits for an in-grid cell.
                busy      = 1'b1;
                heading_d = nh;
                cnt_d     = cnt_q + 8'd1;
                if (uturn && (dead_q != 4'd15)) dead_d = dead_q + 4'd1;
                if (oob) begin
                    state_d = ST_FAULT;
                end else begin
                    pos_x_d = nx;
                    pos_y_d = ny;
                    if ((nx == EXIT_X_V) && (ny == EXIT_Y_V)) state_d = ST_HALT;
                    else if (cnt_d == MAX_V)                  state_d = ST_FAULT;
                    else                                      state_d = ST_SENSE;
                end
            end
            ST_HALT: begin
                busy      = 1'b1;
                cmd_valid = 1'b1;
                if (cmd_ready) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign exp_left  = walls_q[2];
    assign exp_mid   = walls_q[1];
    assign exp_right = walls_q[0];
    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign heading   = heading_q;
    assign dead_ends = dead_q;
    assign move_cnt  = cnt_q;

endmodule

// File: tb/tb_maze_run_sequencer.sv
// Self-checking bench for maze_run_sequencer: directed scenarios plus random
// runs compared against a small arithmetic model of the pose rules.
module tb_maze_run_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       sense_valid;
    logic       left, mid, right;
    logic       exp_left, exp_mid, exp_right;
    logic       exp_step, exp_hold;
    logic [2:0] exp_move;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       cmd_ready;
    logic [3:0] pos_x, pos_y;
    logic [1:0] heading;
    logic [3:0] dead_ends;
    logic [7:0] move_cnt;
    logic       busy, done, fault;

    int total = 0;
    int bad   = 0;

    // Model state: position, heading, counters and run outcome.
    int m_x, m_y, m_h, m_dead, m_cnt, m_out;
    localparam int O_RUN = 0, O_HALT = 1, O_FAULT = 2, O_DONE = 3;

    maze_run_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .sense_valid (sense_valid),
        .left        (left),
        .mid         (mid),
        .right       (right),
        .exp_left    (exp_left),
        .exp_mid     (exp_mid),
        .exp_right   (exp_right),
        .exp_step    (exp_step),
        .exp_hold    (exp_hold),
        .exp_move    (exp_move),
        .cmd_valid   (cmd_valid),
        .cmd         (cmd),
        .cmd_ready   (cmd_ready),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .heading     (heading),
        .dead_ends   (dead_ends),
        .move_cnt    (move_cnt),
        .busy        (busy),
        .done        (done),
        .fault       (fault)
    );

    initial forever #5 clk = ~clk;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task model_start;
        m_x = 4; m_y = 0; m_h = 0; m_dead = 0; m_cnt = 0; m_out = O_RUN;
    endtask

    task model_move(input int code);
        int nx, ny;
        case (code)
            2: m_h = (m_h + 3) % 4;
            3: m_h = (m_h + 1) % 4;
            4: begin
                m_h = (m_h + 2) % 4;
                m_dead = (m_dead < 15) ? m_dead + 1 : 15;
            end
            default: ;
        endcase
        nx = m_x + ((m_h == 1) ? 1 : 0) - ((m_h == 3) ? 1 : 0);
        ny = m_y + ((m_h == 0) ? 1 : 0) - ((m_h == 2) ? 1 : 0);
        m_cnt = m_cnt + 1;
        if (nx < 0 || nx > 8 || ny < 0 || ny > 8) begin
            m_out = O_FAULT;
        end else begin
            m_x = nx;
            m_y = ny;
            if (m_x == 4 && m_y == 8) m_out = O_HALT;
            else if (m_cnt == 200)    m_out = O_FAULT;
            else                      m_out = O_RUN;
        end
    endtask

    task do_reset;
        rst = 1'b1;
        start = 1'b0; sense_valid = 1'b0; cmd_ready = 1'b0;
        #1;
        total++;
        if ({exp_hold, exp_step, cmd_valid, cmd, busy, done, fault,
             exp_left, exp_mid, exp_right, pos_x, pos_y, heading, dead_ends, move_cnt}
            !== {1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0,
                 3'b000, 4'd4, 4'd0, 2'd0, 4'd0, 8'd0}) begin
            bad++;
            $display("[TB] FAIL reset_values: cmd_valid=%0b hold=%0b busy=%0b pos=(%0d,%0d) hd=%0d de=%0d mc=%0d required hold=1 pos=(4,0) rest 0",
                     cmd_valid, exp_hold, busy, pos_x, pos_y, heading, dead_ends, move_cnt);
        end
        tick;
        rst = 1'b0;
        tick;
        m_out = O_RUN;
    endtask

    task start_run;
        start = 1'b1;
        tick;
        start = 1'b0;
        model_start();
        total++;
        if ({busy, exp_hold, done, fault, pos_x, pos_y, heading, dead_ends, move_cnt}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 4'd0, 2'd0, 4'd0, 8'd0}) begin
            bad++;
            $display("[TB] FAIL start_run: busy=%0b hold=%0b pos=(%0d,%0d) hd=%0d de=%0d mc=%0d required busy=1 pos=(4,0) counters 0",
                     busy, exp_hold, pos_x, pos_y, heading, dead_ends, move_cnt);
        end
    endtask

    // One full cell: sense strobe, explorer step, command issue with nwait
    // cycles of backpressure, pose update; completes the STOP handshake too.
    task do_move(input logic [2:0] code, input int nwait, input int halt_wait);
        logic [2:0]  walls;
        logic [21:0] pre;
        logic [21:0] exp_pose;
        bit          seen;
        walls = 3'($urandom_range(0, 7));
        {left, mid, right} = walls;
        sense_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick;
            if (exp_step) seen = 1'b1;
        end
        sense_valid = 1'b0;
        total++;
        if (!seen) begin
            bad++;
            $display("[TB] FAIL step_timeout: exp_step=0 required 1 within 10 cycles");
            m_out = O_FAULT;
            return;
        end
        if ({exp_left, exp_mid, exp_right} !== walls) begin
            bad++;
            $display("[TB] FAIL wall_latch: got %b required %b", {exp_left, exp_mid, exp_right}, walls);
        end
        exp_move = code;
        tick;
        total++;
        if ({cmd_valid, exp_step} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL fetch_quiet: cmd_valid=%0b exp_step=%0b required 0 0", cmd_valid, exp_step);
        end
        tick;
        if (code == 3'd0 || code > 3'd4) begin
            total++;
            if ({fault, busy, cmd_valid} !== 3'b100) begin
                bad++;
                $display("[TB] FAIL illegal_move: fault=%0b busy=%0b cmd_valid=%0b required 1 0 0", fault, busy, cmd_valid);
            end
            m_out = O_FAULT;
            return;
        end
        pre = {4'(m_x), 4'(m_y), 2'(m_h), 4'(m_dead), 8'(m_cnt)};
        for (int i = 0; i <= nwait; i++) begin
            total++;
            if ({cmd_valid, cmd, pos_x, pos_y, heading, dead_ends, move_cnt} !== {1'b1, code, pre}) begin
                bad++;
                $display("[TB] FAIL issue_hold: valid=%0b cmd=%0d pose=%h required valid=1 cmd=%0d pose=%h",
                         cmd_valid, cmd, {pos_x, pos_y, heading, dead_ends, move_cnt}, code, pre);
            end
            if (i == nwait) cmd_ready = 1'b1;
            tick;
        end
        cmd_ready = 1'b0;
        total++;
        if ({cmd_valid, pos_x, pos_y, heading, dead_ends, move_cnt} !== {1'b0, pre}) begin
            bad++;
            $display("[TB] FAIL update_cycle: valid=%0b pose=%h required valid=0 pose=%h",
                     cmd_valid, {pos_x, pos_y, heading, dead_ends, move_cnt}, pre);
        end
        tick;
        model_move(int'(code));
        exp_pose = {4'(m_x), 4'(m_y), 2'(m_h), 4'(m_dead), 8'(m_cnt)};
        total++;
        if ({pos_x, pos_y, heading, dead_ends, move_cnt} !== exp_pose) begin
            bad++;
            $display("[TB] FAIL pose: pos=(%0d,%0d) hd=%0d de=%0d mc=%0d required pos=(%0d,%0d) hd=%0d de=%0d mc=%0d",
                     pos_x, pos_y, heading, dead_ends, move_cnt, m_x, m_y, m_h, m_dead, m_cnt);
        end
        total++;
        if (m_out == O_RUN) begin
            if ({busy, cmd_valid, done, fault} !== 4'b1000) begin
                bad++;
                $display("[TB] FAIL status_run: busy/valid/done/fault=%b required 1000", {busy, cmd_valid, done, fault});
            end
        end else if (m_out == O_FAULT) begin
            if ({busy, cmd_valid, done, fault} !== 4'b0001) begin
                bad++;
                $display("[TB] FAIL status_fault: busy/valid/done/fault=%b required 0001", {busy, cmd_valid, done, fault});
            end
        end else begin
            for (int i = 0; i <= halt_wait; i++) begin
                if (i > 0) begin
                    tick;
                    total++;
                end
                if ({busy, cmd_valid, cmd, done, fault} !== {1'b1, 1'b1, 3'd0, 1'b0, 1'b0}) begin
                    bad++;
                    $display("[TB] FAIL halt_stop: busy=%0b valid=%0b cmd=%0d done=%0b required 1 1 0 0", busy, cmd_valid, cmd, done);
                end
            end
            cmd_ready = 1'b1;
            tick;
            cmd_ready = 1'b0;
            total++;
            if ({busy, cmd_valid, done, fault, exp_hold} !== 5'b00101) begin
                bad++;
                $display("[TB] FAIL status_done: busy/valid/done/fault/hold=%b required 00101", {busy, cmd_valid, done, fault, exp_hold});
            end
            m_out = O_DONE;
        end
    endtask

    task test_reset;
        do_reset();
        sense_valid = 1'b1;
        cmd_ready = 1'b1;
        repeat (3) tick;
        sense_valid = 1'b0;
        cmd_ready = 1'b0;
        total++;
        if ({exp_step, exp_hold, busy, cmd_valid} !== 4'b0100) begin
            bad++;
            $display("[TB] FAIL idle_ignores: step/hold/busy/valid=%b required 0100", {exp_step, exp_hold, busy, cmd_valid});
        end
    endtask

    task test_corridor;
        start_run();
        do_move(3'd1, 0, 0);
        do_move(3'd1, 0, 0);
        total++;
        if ({pos_x, pos_y, heading} !== {4'd4, 4'd2, 2'd0}) begin
            bad++;
            $display("[TB] FAIL corridor: pos=(%0d,%0d) hd=%0d required (4,2) hd=0", pos_x, pos_y, heading);
        end
    endtask

    task test_dead_end;
        do_move(3'd4, 0, 0);
        total++;
        if ({pos_x, pos_y, heading, dead_ends} !== {4'd4, 4'd1, 2'd2, 4'd1}) begin
            bad++;
            $display("[TB] FAIL dead_end: pos=(%0d,%0d) hd=%0d de=%0d required (4,1) hd=2 de=1", pos_x, pos_y, heading, dead_ends);
        end
    endtask

    task test_backpressure;
        do_move(3'd2, 5, 0);
    endtask

    task test_exit;
        do_reset();
        start_run();
        for (int i = 0; i < 8; i++) do_move(3'd1, i % 2, 2);
        total++;
        if ({done, busy, move_cnt} !== {1'b1, 1'b0, 8'd8}) begin
            bad++;
            $display("[TB] FAIL exit: done=%0b busy=%0b mc=%0d required 1 0 8", done, busy, move_cnt);
        end
    endtask

    task test_illegal;
        start_run();
        do_move(3'd6, 0, 0);
        start_run();
    endtask

    task test_reset_mid_issue;
        bit seen;
        do_reset();
        start_run();
        do_move(3'd1, 0, 0);
        sense_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick;
            if (exp_step) seen = 1'b1;
        end
        sense_valid = 1'b0;
        exp_move = 3'd3;
        tick;
        tick;
        total++;
        if (cmd_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_issue_valid: cmd_valid=%0b required 1", cmd_valid);
        end
        do_reset();
        total++;
        if ({exp_hold, busy, cmd_valid, pos_x, pos_y} !== {1'b1, 1'b0, 1'b0, 4'd4, 4'd0}) begin
            bad++;
            $display("[TB] FAIL idle_after_reset: hold=%0b busy=%0b valid=%0b pos=(%0d,%0d) required 1 0 0 (4,0)",
                     exp_hold, busy, cmd_valid, pos_x, pos_y);
        end
    endtask

    task test_budget;
        start_run();
        do_move(3'd1, 0, 0);
        for (int i = 0; i < 199; i++) do_move(3'd4, 0, 0);
        total++;
        if ({fault, move_cnt, dead_ends} !== {1'b1, 8'd200, 4'd15}) begin
            bad++;
            $display("[TB] FAIL budget: fault=%0b mc=%0d de=%0d required 1 200 15", fault, move_cnt, dead_ends);
        end
    endtask

    task test_random;
        logic [2:0] code;
        for (int run = 0; run < 8; run++) begin
            start_run();
            for (int k = 0; k < 30 && m_out == O_RUN; k++) begin
                code = ($urandom_range(0, 19) == 0) ? 3'd6 : 3'($urandom_range(1, 4));
                do_move(code, $urandom_range(0, 3), $urandom_range(0, 2));
            end
            if (m_out == O_RUN) do_reset();
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        sense_valid = 1'b0;
        left = 1'b0; mid = 1'b0; right = 1'b0;
        exp_move = 3'd0;
        cmd_ready = 1'b0;
        model_start();
        test_reset();
        test_corridor();
        test_dead_end();
        test_backpressure();
        test_exit();
        test_illegal();
        test_reset_mid_issue();
        test_budget();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
